// File: rtl/aemb2_wbm_copy.sv
// Wishbone classic-cycle block copier: read a word, write it, repeat len times.
// A per-phase ack timeout aborts the command and pulses cmd_err_o.
module aemb2_wbm_copy #(
  parameter int AW  = 13,
  parameter int LW  = 8,
  parameter int TMO = 15
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          cmd_stb_i,
  input  logic [AW-3:0] cmd_src_i,
  input  logic [AW-3:0] cmd_dst_i,
  input  logic [LW-1:0] cmd_len_i,
  output logic          cmd_busy_o,
  output logic          cmd_done_o,
  output logic          cmd_err_o,
  output logic [AW-3:0] wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  output logic [3:0]    wbm_sel_o,
  output logic          wbm_stb_o,
  output logic          wbm_wre_o,
  output logic          wbm_cyc_o,
  output logic          wbm_tag_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i
);

  // Handshake: a phase completes on the rising edge where stb=1 and ack=1 are
  // both sampled; ack is only looked at in RD/WR, where stb is always high.

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;

  localparam int TW = $clog2(TMO + 1);

  state_t        r_state, w_state;
  logic [AW-3:0] r_src, w_src;
  logic [AW-3:0] r_dst, w_dst;
  logic [LW-1:0] r_len, w_len;
  logic [31:0]   r_dat, w_dat;
  logic [TW-1:0] r_tmo, w_tmo;
  logic          w_tmo_hit;
  logic          w_phase;

  assign w_tmo_hit = (r_tmo == TW'(TMO - 1));
  assign w_phase   = (w_state == S_RD) || (w_state == S_WR);
  assign wbm_tag_o = 1'b0;

  always_comb begin
    w_state = r_state;
    w_src   = r_src;
    w_dst   = r_dst;
    w_len   = r_len;
    w_dat   = r_dat;
    w_tmo   = r_tmo;
    case (r_state)
      S_IDLE: begin
        if (cmd_stb_i) begin
          w_src   = cmd_src_i;
          w_dst   = cmd_dst_i;
          w_len   = cmd_len_i;
          w_tmo   = '0;
          w_state = (cmd_len_i == '0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        if (wbm_ack_i) begin
          w_dat   = wbm_dat_i;
          w_tmo   = '0;
          w_state = S_WR;
        end else if (w_tmo_hit) begin
          w_state = S_ERR;
        end else begin
          w_tmo = r_tmo + TW'(1);
        end
      end
      S_WR: begin
        if (wbm_ack_i) begin
          w_src   = r_src + 1'b1;
          w_dst   = r_dst + 1'b1;
          w_len   = r_len - 1'b1;
          w_tmo   = '0;
          w_state = (r_len == LW'(1)) ? S_DONE : S_RD;
        end else if (w_tmo_hit) begin
          w_state = S_ERR;
        end else begin
          w_tmo = r_tmo + TW'(1);
        end
      end
      S_DONE:  w_state = S_IDLE;
      S_ERR:   w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so the bus sees them
  // in the cycle that state is occupied.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_dat      <= '0;
      r_tmo      <= '0;
      cmd_busy_o <= 1'b0;
      cmd_done_o <= 1'b0;
      cmd_err_o  <= 1'b0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_sel_o  <= 4'h0;
      wbm_stb_o  <= 1'b0;
      wbm_wre_o  <= 1'b0;
      wbm_cyc_o  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_src      <= w_src;
      r_dst      <= w_dst;
      r_len      <= w_len;
      r_dat      <= w_dat;
      r_tmo      <= w_tmo;
      cmd_busy_o <= (w_state != S_IDLE);
      cmd_done_o <= (w_state == S_DONE);
      cmd_err_o  <= (w_state == S_ERR);
      wbm_adr_o  <= (w_state == S_RD) ? w_src : (w_state == S_WR) ? w_dst : '0;
      wbm_dat_o  <= (w_state == S_WR) ? w_dat : 32'h0;
      wbm_sel_o  <= w_phase ? 4'hF : 4'h0;
      wbm_stb_o  <= w_phase;
      wbm_wre_o  <= (w_state == S_WR);
      wbm_cyc_o  <= w_phase;
    end
  end

endmodule

// File: tb/tb_aemb2_wbm_copy.sv
// Randomised bench for aemb2_wbm_copy: RAM slave with variable ack latency,
// a copy reference model feeding an expected-transfer queue, and a monitor.
module tb_aemb2_wbm_copy;

  localparam int AW  = 13;
  localparam int LW  = 8;
  localparam int TMO = 15;
  localparam int WA  = AW - 2;
  localparam int W   = 1 + WA + 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_stb = 1'b0;
  logic [WA-1:0] cmd_src = '0;
  logic [WA-1:0] cmd_dst = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_busy, cmd_done, cmd_err;
  logic [WA-1:0] wbm_adr;
  logic [31:0]   wbm_dat_o;
  logic [3:0]    wbm_sel;
  logic          wbm_stb, wbm_wre, wbm_cyc, wbm_tag;
  logic [31:0]   wbm_dat_i = '0;
  logic          wbm_ack = 1'b0;

  aemb2_wbm_copy #(.AW(AW), .LW(LW), .TMO(TMO)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .cmd_stb_i(cmd_stb), .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len),
    .cmd_busy_o(cmd_busy), .cmd_done_o(cmd_done), .cmd_err_o(cmd_err),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel),
    .wbm_stb_o(wbm_stb), .wbm_wre_o(wbm_wre), .wbm_cyc_o(wbm_cyc), .wbm_tag_o(wbm_tag),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc_n = 0;
  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // ---------------- shared state ----------------
  logic [31:0]  mem    [2**WA];
  logic [31:0]  shadow [2**WA];
  logic [W-1:0] exp_q[$];
  logic         evt_q[$];
  int checks = 0;
  int errors = 0;
  int n_acks = 0;
  int n_stb  = 0;
  int n_wr   = 0;
  int lat_mode = 1;   // >=0 fixed ack latency, -1 random 0..4, -2 never ack

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_cmd(input logic [WA-1:0] s, input logic [WA-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [WA-1:0] sa, da;
      logic [31:0]   v;
      sa = s + WA'(i);
      da = d + WA'(i);
      v  = shadow[sa];
      exp_q.push_back({1'b0, sa, 32'h0});
      exp_q.push_back({1'b1, da, v});
      shadow[da] = v;
    end
    evt_q.push_back(1'b0);
  endtask

  // ---------------- slave: RAM with programmable ack latency ----------------
  initial begin : slave
    int   cnt;
    int   lat;
    logic xfer;
    cnt = 0;
    lat = 0;
    forever begin
      @(negedge clk);
      xfer = wbm_stb && wbm_ack && !rst;
      if (xfer && wbm_wre) mem[wbm_adr] = wbm_dat_o;
      @(posedge clk);
      #1;
      if (rst || xfer || !wbm_stb) cnt = 0;
      wbm_ack   = 1'b0;
      wbm_dat_i = $urandom;
      if (!rst && wbm_stb) begin
        if (cnt == 0)
          lat = (lat_mode == -1) ? int'($urandom_range(0, 4)) :
                (lat_mode == -2) ? 1000 : lat_mode;
        if (cnt == lat) begin
          wbm_ack = 1'b1;
          if (!wbm_wre) wbm_dat_i = mem[wbm_adr];
        end
        cnt++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("tag", 64'(wbm_tag), 64'd0);
        if (wbm_stb) begin
          n_stb++;
          check("sel_active", 64'(wbm_sel), 64'hF);
          check("cyc_with_stb", 64'(wbm_cyc), 64'd1);
        end else begin
          check("sel_idle", 64'(wbm_sel), 64'h0);
          check("wre_idle", 64'(wbm_wre), 64'd0);
        end
        if (wbm_stb && wbm_ack) begin
          n_acks++;
          if (wbm_wre) n_wr++;
          if (exp_q.size() == 0) begin
            check("unexpected_xfer", 64'(wbm_adr), 64'hFFFF_FFFF);
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("xfer", 64'({wbm_wre, wbm_adr, (wbm_wre ? wbm_dat_o : 32'h0)}), 64'(e));
          end
        end
        if (cmd_done || cmd_err) begin
          if (evt_q.size() == 0) begin
            check("unexpected_end", 64'({cmd_done, cmd_err}), 64'd0);
          end else begin
            logic e;
            e = evt_q.pop_front();
            check("end_kind_err", 64'(cmd_err), 64'(e));
            check("end_kind_done", 64'(cmd_done), 64'(!e));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called mid-cycle; the command is accepted on the next rising edge.
  task automatic start(input logic [WA-1:0] s, input logic [WA-1:0] d, input logic [LW-1:0] n);
    cmd_src = s;
    cmd_dst = d;
    cmd_len = n;
    cmd_stb = 1'b1;
    @(posedge clk);
    #1;
    cmd_stb = 1'b0;
    cmd_src = WA'($urandom);
    cmd_dst = WA'($urandom);
    cmd_len = LW'($urandom);
  endtask

  // Waits for done/err; returns its cycle number and leaves us just after the next edge.
  task automatic wait_end(input string name, output int at);
    at = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cmd_done || cmd_err) begin
        at = cyc_n;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL %s_timeout actual=no_end required=done_or_err", name);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int t_stb, t_end, a0, s0, w0;
    logic [31:0] old_v[5];
    logic [31:0] new_v[5];
    logic        seen_stb;

    for (int i = 0; i < 2**WA; i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(cmd_busy), 64'd0);
    check("rst_done_err", 64'({cmd_done, cmd_err}), 64'd0);
    check("rst_bus", 64'({wbm_stb, wbm_cyc, wbm_wre, wbm_sel}), 64'd0);
    check("rst_adr_dat", 64'({wbm_adr, wbm_dat_o}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 4-word copy against registered-ack RAM
    for (int i = 0; i < 4; i++) begin
      mem[32'h10 + i]    = 32'hA000_0000 + i;
      shadow[32'h10 + i] = 32'hA000_0000 + i;
    end
    lat_mode = 1;
    a0 = n_acks;
    push_cmd(WA'(11'h010), WA'(11'h100), 4);
    start(WA'(11'h010), WA'(11'h100), 8'd4);
    @(negedge clk);
    check("start_busy", 64'(cmd_busy), 64'd1);
    check("start_stb_rd", 64'({wbm_stb, wbm_wre, wbm_adr}), 64'({1'b1, 1'b0, 11'h010}));
    t_stb = cyc_n;
    wait_end("copy4", t_end);
    check("copy4_latency", 64'(t_end - t_stb), 64'd16);
    check("copy4_acks", 64'(n_acks - a0), 64'd8);
    for (int i = 0; i < 4; i++)
      check("copy4_ram", 64'(mem[32'h100 + i]), 64'(32'hA000_0000 + i));
    @(negedge clk);
    check("after_done_idle", 64'({cmd_busy, wbm_cyc, wbm_stb}), 64'd0);
    @(posedge clk);
    #1;

    // zero-length command
    s0 = n_stb;
    push_cmd(WA'(11'h123), WA'(11'h456), 0);
    start(WA'(11'h123), WA'(11'h456), 8'd0);
    @(negedge clk);
    check("len0_done", 64'({cmd_done, cmd_busy, wbm_stb}), 64'({1'b1, 1'b1, 1'b0}));
    @(negedge clk);
    check("len0_after", 64'({cmd_done, cmd_busy}), 64'd0);
    check("len0_no_stb", 64'(n_stb - s0), 64'd0);
    @(posedge clk);
    #1;

    // address wrap at the top of the word space
    lat_mode = -1;
    push_cmd(WA'(11'h7FE), WA'(11'h002), 3);
    start(WA'(11'h7FE), WA'(11'h002), 8'd3);
    wait_end("wrap", t_end);
    for (int i = 0; i < 3; i++)
      check("wrap_ram", 64'(mem[2 + i]), 64'(shadow[2 + i]));

    // slave never acks: abort after TMO cycles, next start in the following cycle
    lat_mode = -2;
    s0 = n_stb;
    evt_q.push_back(1'b1);
    start(WA'(11'h020), WA'(11'h030), 8'd2);
    wait_end("tmo", t_end);
    check("tmo_stb_cycles", 64'(n_stb - s0), 64'(TMO));
    check("tmo_bus_idle", 64'({wbm_cyc, wbm_stb, cmd_busy}), 64'd0);
    lat_mode = 1;
    push_cmd(WA'(11'h040), WA'(11'h050), 1);
    start(WA'(11'h040), WA'(11'h050), 8'd1);
    @(negedge clk);
    check("tmo_restart", 64'({cmd_busy, wbm_stb}), 64'h3);
    wait_end("tmo_restart", t_end);

    // ack arriving in the last allowed cycle wins; one cycle later loses
    lat_mode = TMO - 1;
    push_cmd(WA'(11'h060), WA'(11'h070), 1);
    start(WA'(11'h060), WA'(11'h070), 8'd1);
    wait_end("tmo_edge_ok", t_end);
    lat_mode = TMO;
    s0 = n_stb;
    evt_q.push_back(1'b1);
    start(WA'(11'h080), WA'(11'h090), 8'd1);
    wait_end("tmo_edge_err", t_end);
    check("tmo_edge_stb", 64'(n_stb - s0), 64'(TMO));

    // reset during the third write of a 5-word copy
    lat_mode = 1;
    for (int i = 0; i < 5; i++) begin
      old_v[i] = shadow[32'h300 + i];
      new_v[i] = shadow[32'h200 + i];
    end
    w0 = n_wr;
    push_cmd(WA'(11'h200), WA'(11'h300), 5);
    start(WA'(11'h200), WA'(11'h300), 8'd5);
    seen_stb = 1'b0;
    for (int k = 0; k < 100 && !seen_stb; k++) begin
      @(negedge clk);
      #1;
      if (n_wr - w0 == 2 && wbm_stb && wbm_wre && !wbm_ack) seen_stb = 1'b1;
    end
    check("rst_mid_reached", 64'(seen_stb), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    evt_q.delete();
    @(negedge clk);
    check("rst_mid_bus", 64'({wbm_stb, wbm_cyc, cmd_busy, cmd_done, cmd_err}), 64'd0);
    repeat (5) @(negedge clk);
    check("rst_mid_writes", 64'(n_wr - w0), 64'd2);
    for (int i = 0; i < 5; i++) begin
      check("rst_mid_ram", 64'(mem[32'h300 + i]), 64'(i < 2 ? new_v[i] : old_v[i]));
      shadow[32'h300 + i] = (i < 2) ? new_v[i] : old_v[i];
    end
    @(posedge clk);
    #1;

    // start pulse while busy is ignored
    lat_mode = -1;
    push_cmd(WA'(11'h400), WA'(11'h480), 3);
    start(WA'(11'h400), WA'(11'h480), 8'd3);
    repeat (2) @(posedge clk);
    #1;
    start(WA'(11'h7AA), WA'(11'h7BB), 8'd9);
    wait_end("busy_ignore", t_end);
    s0 = n_stb;
    repeat (6) @(negedge clk);
    check("busy_ignore_no_second", 64'(n_stb - s0), 64'd0);
    @(posedge clk);
    #1;

    // randomised commands
    for (int n = 0; n < 30; n++) begin
      logic [WA-1:0] s, d;
      int            len;
      s   = WA'($urandom_range(0, 2**WA - 1));
      d   = WA'($urandom_range(0, 2**WA - 1));
      len = $urandom_range(0, 6);
      lat_mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO - 1)) : -1;
      push_cmd(s, d, len);
      start(s, d, LW'(len));
      wait_end("rand", t_end);
    end

    repeat (4) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("evt_q_empty", 64'(evt_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
